// File: rtl/tsd_pkg.sv
// Shared defaults and helpers for the tristate_bus_driver codebase slice.
// Optional keeper behaviour across the slice is selected by BUS_KEEPER_EN.
package tsd_pkg;

   localparam int unsigned TSD_WIDTH  = 32;
   localparam int unsigned TSD_LANE_W = 8;
   localparam int unsigned TSD_CNT_W  = 16;

   function automatic int unsigned lane_count(input int unsigned width,
                                              input int unsigned lane_w);
      return width / lane_w;
   endfunction

   typedef logic [lane_count(TSD_WIDTH, TSD_LANE_W)-1:0] lane_mask_t;

endpackage

// File: rtl/tsd_lane.sv
// Single LANE_W-bit enable-gated driver; releases to Z, or to the kept value
// when BUS_KEEPER_EN is defined.
module tsd_lane import tsd_pkg::*; #(
   parameter int unsigned LANE_W = TSD_LANE_W
) (
   input  logic              i_en,
   input  logic [LANE_W-1:0] i_data,
`ifdef BUS_KEEPER_EN
   input  logic [LANE_W-1:0] i_keep,
`endif
   output wire  [LANE_W-1:0] o_lane
);

   // An X on i_en yields X on the lane rather than Z, which is intended.
`ifdef BUS_KEEPER_EN
   assign o_lane = i_en ? i_data : i_keep;
`else
   assign o_lane = i_en ? i_data : {LANE_W{1'bz}};
`endif

endmodule

// File: rtl/tristate_bus_driver.sv
// Lane-granular tri-state read-data bus driver with drive-activity status.
// Define BUS_KEEPER_EN to hold the last driven value on released lanes.
module tristate_bus_driver import tsd_pkg::*; #(
   parameter int unsigned WIDTH  = TSD_WIDTH,
   parameter int unsigned LANE_W = TSD_LANE_W,
   parameter int unsigned CNT_W  = TSD_CNT_W
) (
   output wire  [WIDTH-1:0]        data_out,
   input  logic [WIDTH-1:0]        data_in,
   input  logic                    en,
   input  logic [WIDTH/LANE_W-1:0] lane_mask,
   input  logic                    clk,
   input  logic                    rst,
   output logic                    driving,
   output logic                    en_rise,
   output logic [CNT_W-1:0]        drive_cnt
);

   localparam int unsigned LANES = lane_count(WIDTH, LANE_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (WIDTH % LANE_W != 0) begin : g_bad_width
      $error("tristate_bus_driver: WIDTH must be a multiple of LANE_W");
   end

   logic [LANES-1:0] w_lane_en;
   logic             r_en_q;
   logic             r_en_rise;
   logic [CNT_W-1:0] r_drive_cnt;

   assign w_lane_en = {LANES{en}} & lane_mask;
   assign driving   = en & (|lane_mask);
   assign en_rise   = r_en_rise;
   assign drive_cnt = r_drive_cnt;

   // en_q follows en even in reset so an en held across release gives no pulse.
   always_ff @(posedge clk) begin
      r_en_q <= en;
      if (rst) begin
         r_en_rise   <= 1'b0;
         r_drive_cnt <= '0;
      end else begin
         r_en_rise <= en & ~r_en_q;
         if (driving && (r_drive_cnt != CNT_MAX)) begin
            r_drive_cnt <= r_drive_cnt + CNT_W'(1);
         end
      end
   end

`ifdef BUS_KEEPER_EN
   logic [WIDTH-1:0] r_keep;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_keep <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (w_lane_en[i]) begin
               r_keep[i*LANE_W +: LANE_W] <= data_in[i*LANE_W +: LANE_W];
            end
         end
      end
   end
`endif

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      tsd_lane #(
         .LANE_W (LANE_W)
      ) u_lane (
         .i_en   (w_lane_en[gi]),
         .i_data (data_in[gi*LANE_W +: LANE_W]),
`ifdef BUS_KEEPER_EN
         .i_keep (r_keep[gi*LANE_W +: LANE_W]),
`endif
         .o_lane (data_out[gi*LANE_W +: LANE_W])
      );
   end

endmodule

// File: tb/tb_tristate_bus_driver.sv
// Bench for tristate_bus_driver: pulled-up and pulled-down instances expose Z lanes.
// Keeper-specific checks are compiled in when BUS_KEEPER_EN is defined.
module tb_tristate_bus_driver;
   import tsd_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   lane_mask_t  lane_mask = '0;
   logic [31:0] data_in = '0;

   tri1 [31:0]  dout_a;
   tri0 [31:0]  dout_b;
   logic        drv_a, drv_b, rise_a, rise_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          m_cnt_a = 0;
   int          m_cnt_b = 0;
   logic        m_rise = 1'b0;
   logic        m_prev = 1'b0;
   logic [31:0] m_keep = '0;

   always #5 clk = ~clk;

   tristate_bus_driver #(.WIDTH(32), .LANE_W(8), .CNT_W(16)) u_dut_a (
      .data_out  (dout_a),
      .data_in   (data_in),
      .en        (en),
      .lane_mask (lane_mask),
      .clk       (clk),
      .rst       (rst),
      .driving   (drv_a),
      .en_rise   (rise_a),
      .drive_cnt (cnt_a)
   );

   tristate_bus_driver #(.WIDTH(32), .LANE_W(8), .CNT_W(4)) u_dut_b (
      .data_out  (dout_b),
      .data_in   (data_in),
      .en        (en),
      .lane_mask (lane_mask),
      .clk       (clk),
      .rst       (rst),
      .driving   (drv_b),
      .en_rise   (rise_b),
      .drive_cnt (cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Expected bus as seen through a pull of value 'pull' on undriven lanes.
   function automatic logic [31:0] exp_out(input logic pull);
      logic [31:0] r;
      for (int l = 0; l < 4; l++) begin
         if (en && lane_mask[l]) r[l*8 +: 8] = data_in[l*8 +: 8];
`ifdef BUS_KEEPER_EN
         else r[l*8 +: 8] = m_keep[l*8 +: 8];
`else
         else r[l*8 +: 8] = {8{pull}};
`endif
      end
      return r;
   endfunction

   task automatic drive(input logic r, input logic e, input logic [3:0] m, input logic [31:0] d);
      @(negedge clk);
      rst = r;
      en = e;
      lane_mask = m;
      data_in = d;
      #1;
      check("dout_a", dout_a, exp_out(1'b1));
      check("dout_b", dout_b, exp_out(1'b0));
      check("driving_a", {31'b0, drv_a}, {31'b0, en && (lane_mask != 0)});
      check("driving_b", {31'b0, drv_b}, {31'b0, en && (lane_mask != 0)});
   endtask

   task automatic tick();
      logic drv;
      @(posedge clk);
      drv = en && (lane_mask != 0);
      if (rst) begin
         m_cnt_a = 0;
         m_cnt_b = 0;
         m_rise = 1'b0;
         m_keep = '0;
      end else begin
         m_rise = en && !m_prev;
         if (drv) begin
            m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
            m_cnt_b = (m_cnt_b + 1 > 15) ? 15 : m_cnt_b + 1;
         end
         for (int l = 0; l < 4; l++)
            if (en && lane_mask[l]) m_keep[l*8 +: 8] = data_in[l*8 +: 8];
      end
      m_prev = en;
      #1;
      check("en_rise_a", {31'b0, rise_a}, {31'b0, m_rise});
      check("en_rise_b", {31'b0, rise_b}, {31'b0, m_rise});
      check("cnt_a", {16'b0, cnt_a}, m_cnt_a);
      check("cnt_b", {28'b0, cnt_b}, m_cnt_b);
   endtask

   initial begin
      // Reset for two cycles with en low
      repeat (2) begin drive(1'b1, 1'b0, 4'hF, 32'h0); tick(); end
      check("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
      check("rst_rise_a", {31'b0, rise_a}, 32'd0);

      drive(1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
      check("full_a", dout_a, 32'hDEADBEEF);
      check("full_b", dout_b, 32'hDEADBEEF);
      check("full_drv", {31'b0, drv_a}, 32'd1);
      tick();
      check("rise_first", {31'b0, rise_a}, 32'd1);
      drive(1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
      tick();
      check("rise_once", {31'b0, rise_a}, 32'd0);

      drive(1'b0, 1'b0, 4'hF, 32'h12345678);
      tick();
      check("idle_cnt", {16'b0, cnt_a}, 32'd2);
      check("idle_drv", {31'b0, drv_a}, 32'd0);
`ifndef BUS_KEEPER_EN
      check("idle_z_a", dout_a, 32'hFFFFFFFF);
      check("idle_z_b", dout_b, 32'h00000000);
`endif

      drive(1'b0, 1'b1, 4'b0101, 32'hAABBCCDD);
`ifndef BUS_KEEPER_EN
      check("lanes_a", dout_a, 32'hFFBBFFDD);
      check("lanes_b", dout_b, 32'h00BB00DD);
`endif
      tick();

      // Reset then five driven cycles
      repeat (2) begin drive(1'b1, 1'b0, 4'hF, 32'h0); tick(); end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 4'hF, $urandom);
         tick();
         check("rise_pulse", {31'b0, rise_a}, {31'b0, i == 0});
      end
      check("cnt_five", {16'b0, cnt_a}, 32'd5);

      // en held high across reset release
      repeat (2) begin drive(1'b1, 1'b1, 4'hF, 32'h0); tick(); end
      drive(1'b0, 1'b1, 4'hF, 32'h0);
      tick();
      check("no_rise_held", {31'b0, rise_a}, 32'd0);
      check("cnt_resume", {16'b0, cnt_a}, 32'd1);

      // Saturation on the CNT_W=4 instance
      repeat (20) begin drive(1'b0, 1'b1, 4'hF, $urandom); tick(); end
      check("sat_b", {28'b0, cnt_b}, 32'd15);
      check("cnt_a_21", {16'b0, cnt_a}, 32'd21);

`ifdef BUS_KEEPER_EN
      drive(1'b0, 1'b1, 4'hF, 32'hCAFEF00D);
      tick();
      drive(1'b0, 1'b0, 4'hF, 32'h0);
      check("keep_a", dout_a, 32'hCAFEF00D);
      check("keep_b", dout_b, 32'hCAFEF00D);
      tick();
      drive(1'b1, 1'b0, 4'hF, 32'h0);
      tick();
      drive(1'b0, 1'b0, 4'hF, 32'h0);
      check("keep_rst", dout_a, 32'h00000000);
      tick();
`endif

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
               4'($urandom_range(0, 15)), $urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
